// File: rtl/exception_redirect_ctrl_pkg.sv
// Shared types and defaults for the exception redirect sequencer.
//   state_e              : recovery sequence states
//   FLUSH_CYCLES_DEF     : default flush hold length
//   MAX_OUTSTANDING_DEF  : default per-bus in-flight limit
package exception_redirect_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COMMIT,
        FLUSH,
        DRAIN,
        REDIRECT
    } state_e;

    localparam int FLUSH_CYCLES_DEF    = 2;
    localparam int MAX_OUTSTANDING_DEF = 4;

endpackage

// File: rtl/exception_redirect_ctrl_counter.sv
// Saturating in-flight transaction counter for one bus.
//   clk, rst : clock, async active-low reset
//   inc      : request accepted
//   dec      : response returned
//   count    : transactions currently in flight
//   err      : sticky over/underflow flag
module outstanding_counter #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         err
);

    // inc and dec together cancel; an illegal step holds the count and flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            err   <= 1'b0;
        end else if (inc && !dec) begin
            if (count == W'(MAX)) err   <= 1'b1;
            else                  count <= count + 1'b1;
        end else if (dec && !inc) begin
            if (count == '0) err   <= 1'b1;
            else             count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/exception_redirect_ctrl.sv
// Exception / ERET recovery sequencer: commit CP0, flush, drain buses, redirect.
//   clk, rst             : clock, async active-low reset
//   exp_detect/is_eret   : one-cycle decision from the exception unit
//   exp_target           : redirect PC for that decision
//   ibus_*/dbus_*        : request-accept / response strobes per bus
//   redirect_ready       : fetch accepts redirect
//   exp_busy             : recovery in progress
//   cp0_commit(_eret)    : CP0 update strobe, ERET qualifier
//   pipe_stall/flush     : pipeline control
//   redirect_valid/pc    : handshake to fetch
//   exp_dropped          : sticky, decision arrived while busy
//   cnt_error            : sticky, outstanding counter over/underflow
module exception_redirect_ctrl
    import exception_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES    = FLUSH_CYCLES_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exp_detect,
    input  logic        exp_is_eret,
    input  logic [31:0] exp_target,
    input  logic        ibus_req_fire,
    input  logic        ibus_resp,
    input  logic        dbus_req_fire,
    input  logic        dbus_resp,
    input  logic        redirect_ready,
    output logic        exp_busy,
    output logic        cp0_commit,
    output logic        cp0_commit_eret,
    output logic        pipe_stall,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        exp_dropped,
    output logic        cnt_error
);

    state_e             state, nxt_state;
    logic [3:0]         flush_cnt, flush_cnt_d;
    logic [31:0]        tgt_q;
    logic               eret_q;
    logic [CNT_W-1:0]   ibus_cnt, dbus_cnt;
    logic               ibus_err, dbus_err;

    outstanding_counter #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_ibus_cnt (
        .clk(clk), .rst(rst), .inc(ibus_req_fire), .dec(ibus_resp),
        .count(ibus_cnt), .err(ibus_err)
    );

    outstanding_counter #(.MAX(MAX_OUTSTANDING), .W(CNT_W)) u_dbus_cnt (
        .clk(clk), .rst(rst), .inc(dbus_req_fire), .dec(dbus_resp),
        .count(dbus_cnt), .err(dbus_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= nxt_state;
            flush_cnt <= flush_cnt_d;
        end
    end

    // Decision is captured only when accepted; anything arriving while
    // busy (including the cycle REDIRECT completes) is dropped and flagged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_q       <= '0;
            eret_q      <= 1'b0;
            exp_dropped <= 1'b0;
        end else if (exp_detect) begin
            if (state == IDLE) begin
                tgt_q  <= exp_target;
                eret_q <= exp_is_eret;
            end else begin
                exp_dropped <= 1'b1;
            end
        end
    end

    always_comb begin
        nxt_state       = state;
        flush_cnt_d     = flush_cnt;
        exp_busy        = 1'b1;
        cp0_commit      = 1'b0;
        cp0_commit_eret = 1'b0;
        pipe_stall      = 1'b1;
        pipe_flush      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        case (state)
            IDLE: begin
                exp_busy   = 1'b0;
                pipe_stall = 1'b0;
                if (exp_detect) nxt_state = COMMIT;
            end
            COMMIT: begin
                cp0_commit      = 1'b1;
                cp0_commit_eret = eret_q;
                flush_cnt_d     = 4'(FLUSH_CYCLES - 1);
                nxt_state       = FLUSH;
            end
            FLUSH: begin
                pipe_flush = 1'b1;
                if (flush_cnt == '0) nxt_state   = DRAIN;
                else                 flush_cnt_d = flush_cnt - 1'b1;
            end
            DRAIN: begin
                // Registered counts: a final response lands one cycle later.
                if (ibus_cnt == '0 && dbus_cnt == '0) nxt_state = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = tgt_q;
                if (redirect_ready) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    assign cnt_error = ibus_err | dbus_err;

endmodule

// File: tb/tb_exception_redirect_ctrl.sv
module tb_exception_redirect_ctrl;

    localparam int F = 2;
    localparam int M = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exp_detect = 0, exp_is_eret = 0;
    logic [31:0] exp_target = '0;
    logic        ibus_req_fire = 0, ibus_resp = 0, dbus_req_fire = 0, dbus_resp = 0;
    logic        redirect_ready = 0;
    logic        exp_busy, cp0_commit, cp0_commit_eret, pipe_stall, pipe_flush;
    logic        redirect_valid, exp_dropped, cnt_error;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    exception_redirect_ctrl #(.FLUSH_CYCLES(F), .MAX_OUTSTANDING(M)) u_dut (
        .clk(clk), .rst(rst),
        .exp_detect(exp_detect), .exp_is_eret(exp_is_eret), .exp_target(exp_target),
        .ibus_req_fire(ibus_req_fire), .ibus_resp(ibus_resp),
        .dbus_req_fire(dbus_req_fire), .dbus_resp(dbus_resp),
        .redirect_ready(redirect_ready),
        .exp_busy(exp_busy), .cp0_commit(cp0_commit), .cp0_commit_eret(cp0_commit_eret),
        .pipe_stall(pipe_stall), .pipe_flush(pipe_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .exp_dropped(exp_dropped), .cnt_error(cnt_error)
    );

    int n_chk = 0, n_pass = 0;

    // Reference model: recovery is tracked as "cycles since acceptance"
    // plus a redirect-pending flag; counters are plain saturating ints.
    bit          m_busy, m_redir, m_eret, m_drop, m_err;
    int          m_age, m_ic, m_dc;
    logic [31:0] m_tgt;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        m_busy = 0; m_redir = 0; m_eret = 0; m_drop = 0; m_err = 0;
        m_age = 0; m_ic = 0; m_dc = 0; m_tgt = '0;
    endtask

    function automatic void bump(inout int c, inout bit e, input bit up, input bit dn);
        if (up && !dn) begin
            if (c == M) e = 1; else c++;
        end else if (dn && !up) begin
            if (c == 0) e = 1; else c--;
        end
    endfunction

    task automatic model_step();
        if (!m_busy) begin
            if (exp_detect) begin
                m_busy = 1; m_age = 1; m_redir = 0;
                m_tgt = exp_target; m_eret = exp_is_eret;
            end
        end else begin
            if (exp_detect) m_drop = 1;
            if (m_redir) begin
                if (redirect_ready) begin m_busy = 0; m_redir = 0; end
            end else if (m_age >= 2 + F && m_ic == 0 && m_dc == 0) begin
                m_redir = 1;
            end
            m_age++;
        end
        bump(m_ic, m_err, ibus_req_fire, ibus_resp);
        bump(m_dc, m_err, dbus_req_fire, dbus_resp);
    endtask

    task automatic cmp_model();
        bit cm;
        cm = m_busy && m_age == 1;
        check("busy",   32'(exp_busy),        32'(m_busy));
        check("commit", 32'(cp0_commit),      32'(cm));
        check("eret",   32'(cp0_commit_eret), 32'(cm && m_eret));
        check("stall",  32'(pipe_stall),      32'(m_busy));
        check("flush",  32'(pipe_flush),      32'(m_busy && m_age >= 2 && m_age <= 1 + F));
        check("rvalid", 32'(redirect_valid),  32'(m_redir));
        check("rpc",    redirect_pc,          m_redir ? m_tgt : 32'h0);
        check("drop",   32'(exp_dropped),     32'(m_drop));
        check("cnterr", 32'(cnt_error),       32'(m_err));
    endtask

    // One clock: drive inputs, check current outputs, advance DUT and model.
    task automatic cyc(input bit det, input bit eret, input logic [31:0] tgt,
                       input bit iq, input bit ir, input bit dq, input bit dr, input bit rdy);
        exp_detect = det; exp_is_eret = eret; exp_target = tgt;
        ibus_req_fire = iq; ibus_resp = ir; dbus_req_fire = dq; dbus_resp = dr;
        redirect_ready = rdy;
        cmp_model();
        @(posedge clk); #1;
        model_step();
    endtask

    task automatic do_reset();
        exp_detect = 0; exp_is_eret = 0; exp_target = '0;
        ibus_req_fire = 0; ibus_resp = 0; dbus_req_fire = 0; dbus_resp = 0;
        redirect_ready = 0;
        rst = 0;
        #1;
        model_reset();
        cmp_model();
        @(posedge clk); @(posedge clk); #1;
        rst = 1;
    endtask

    logic [31:0] pc_hold;

    initial begin
        // 1: basic latency
        do_reset();
        check("rst_pc", redirect_pc, 32'h0);
        cyc(1, 0, 32'hBFC00380, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            check("t1_commit", 32'(cp0_commit),     32'(k == 1));
            check("t1_flush",  32'(pipe_flush),     32'(k == 2 || k == 3));
            check("t1_rvalid", 32'(redirect_valid), 32'(k == 5));
            check("t1_busy",   32'(exp_busy),       32'(k <= 5));
            if (k == 5) check("t1_pc", redirect_pc, 32'hBFC00380);
            cyc(0, 0, '0, 0, 0, 0, 0, 1);
        end

        // 2 + 4: ERET with redirect backpressure
        cyc(1, 1, 32'h80001234, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) check("t2_eret", 32'(cp0_commit_eret), 32'h1);
            if (k >= 5 && k <= 9) begin
                check("t4_rvalid", 32'(redirect_valid), 32'h1);
                check("t4_pc",     redirect_pc,         32'h80001234);
                check("t4_stall",  32'(pipe_stall),     32'h1);
            end
            if (k == 10) check("t4_idle", 32'(exp_busy), 32'h0);
            cyc(0, 0, '0, 0, 0, 0, 0, k >= 9);
        end

        // 3: drain with 3 outstanding data transactions
        do_reset();
        repeat (3) cyc(0, 0, '0, 0, 0, 1, 0, 1);
        cyc(1, 0, 32'h00400000, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 13; k++) begin
            if (k == 8)  check("t3_cnt_same", 32'(u_dut.u_dbus_cnt.count), 32'd2);
            if (k == 11) check("t3_rv_low",   32'(redirect_valid), 32'h0);
            if (k == 12) check("t3_rv_rise",  32'(redirect_valid), 32'h1);
            cyc(0, 0, '0, 0, 0, k == 7, k == 6 || k == 7 || k == 8 || k == 10, 1);
        end

        // 5: detect during FLUSH is dropped; then counter overflow
        do_reset();
        cyc(1, 0, 32'hA0000000, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) check("t5_drop", 32'(exp_dropped), 32'h1);
            if (k == 5) check("t5_pc",   redirect_pc,      32'hA0000000);
            cyc(k == 2, 0, 32'h12345678, 0, 0, 0, 0, 1);
        end
        repeat (5) cyc(0, 0, '0, 1, 0, 0, 0, 1);
        check("t5_sat",    32'(u_dut.u_ibus_cnt.count), 32'd4);
        check("t5_cnterr", 32'(cnt_error),              32'h1);

        // 6: async reset mid-DRAIN
        do_reset();
        cyc(0, 0, '0, 0, 0, 1, 0, 1);
        cyc(1, 0, 32'hDEAD0000, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 5; k++) cyc(0, 0, '0, 0, 0, 0, 0, 1);
        check("t6_in_drain", 32'(exp_busy & ~redirect_valid), 32'h1);
        #2 rst = 0;
        #1;
        check("t6_busy",   32'(exp_busy),       32'h0);
        check("t6_stall",  32'(pipe_stall),     32'h0);
        check("t6_rvalid", 32'(redirect_valid), 32'h0);
        check("t6_pc",     redirect_pc,         32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1;
        repeat (10) cyc(0, 0, '0, 0, 0, 0, 0, 1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exception_redirect_ctrl.md
Name: exception_redirect_ctrl

Overview:
Sequencer that turns a one-cycle exception or ERET decision from the exception unit into an ordered recovery:
- commit the CP0 update;
- flush the pipeline;
- drain in-flight instruction/data bus transactions;
- hand the redirect PC to fetch over a valid/ready handshake.

It sits between the exception unit, CP0, the pipeline stall/flush network and the fetch stage. It also exports a busy flag that masks new exception detection while recovery is in progress.

Parameters:
- FLUSH_CYCLES, 2: number of cycles pipe_flush is held (1..15).
- MAX_OUTSTANDING, 4: maximum in-flight transactions per bus.
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of each outstanding counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- exp_detect  in  1  exception/ERET decision valid this cycle
- exp_is_eret  in  1  qualifies exp_detect as ERET (cp0_exl_clean path)
- exp_target  in  32  redirect PC for this decision (exp_pc_address)
- ibus_req_fire  in  1  instruction bus request accepted
- ibus_resp  in  1  instruction bus response returned
- dbus_req_fire  in  1  data bus request accepted
- dbus_resp  in  1  data bus response returned
- redirect_ready  in  1  fetch accepts the redirect
- exp_busy  out  1  recovery in progress; gates exception detection
- cp0_commit  out  1  one-cycle strobe: CP0 latches exception state
- cp0_commit_eret  out  1  qualifies cp0_commit as an EXL clear
- pipe_stall  out  1  freeze all pipeline stages
- pipe_flush  out  1  invalidate all in-flight pipeline stages
- redirect_valid  out  1  redirect PC valid
- redirect_pc  out  32  redirect target
- exp_dropped  out  1  sticky error: exp_detect arrived while busy
- cnt_error  out  1  sticky error: outstanding counter over/underflow

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE, both counters=0.
- All outputs are 0, including redirect_pc=0 and both sticky errors.
- Reset in any state aborts the sequence with no commit and no redirect.

State machine, all outputs registered from state:
- IDLE: exp_detect=1 latches exp_target and exp_is_eret, then goes to COMMIT.
- COMMIT (1 cycle): cp0_commit=1, cp0_commit_eret=latched eret, pipe_stall=1. Then FLUSH with flush_cnt=FLUSH_CYCLES-1.
- FLUSH: pipe_flush=1 and pipe_stall=1. flush_cnt decrements each cycle; at 0 go to DRAIN.
- DRAIN: pipe_stall=1. Stay while either outstanding counter is nonzero; go to REDIRECT in the cycle both are 0. DRAIN lasts at least 1 cycle.
- REDIRECT: redirect_valid=1, redirect_pc=latched target, pipe_stall=1. redirect_pc is held stable until redirect_ready=1, then go to IDLE.

Common rules:
- exp_busy=1 in every state except IDLE.
- Minimum latency: detect at cycle 0, commit at 1, flush at 2..1+FLUSH_CYCLES, drain at 2+FLUSH_CYCLES, redirect_valid from 3+FLUSH_CYCLES. With defaults, redirect_valid is first high at cycle 5 and the block is back in IDLE at cycle 6 if redirect_ready=1.
- exp_detect while not in IDLE is ignored and sets exp_dropped. exp_dropped clears only on reset.
- exp_detect in the same cycle that REDIRECT completes is ignored and sets exp_dropped. A back-to-back exception is accepted only from IDLE.

Outstanding counters (one per bus):
- Counters keep tracking during every state.
- req_fire alone increments; resp alone decrements; both together leave the count unchanged.
- Increment at MAX_OUTSTANDING, or decrement at 0, holds the value and sets cnt_error (sticky).
- A response arriving in DRAIN in the same cycle that takes the count 1→0 does not exit DRAIN until the next cycle, because the exit condition uses the registered count.

Decomposition:
- Shared package: state enum {IDLE, COMMIT, FLUSH, DRAIN, REDIRECT} and the FLUSH_CYCLES/MAX_OUTSTANDING defaults.
- One sub-module, outstanding_counter (parameters MAX and W; ports inc, dec, count, err), instantiated once for ibus and once for dbus.

Test Plan:
1. Reset, then exp_detect=1 with exp_target=0xBFC00380, no bus traffic, redirect_ready=1 → cp0_commit at cycle 1; pipe_flush at cycles 2–3; redirect_valid with pc 0xBFC00380 at cycle 5; exp_busy low at cycle 6.
2. ERET: exp_is_eret=1, exp_target=0x80001234 → cp0_commit_eret=1 with cp0_commit; redirect_pc=0x80001234.
3. Drain: dbus has 3 outstanding (counter=3) at detect, with responses at cycles 6, 8 and 10 → DRAIN holds until the count reaches 0 and redirect_valid first rises at cycle 12. Also check simultaneous req_fire and resp leaves the count unchanged.
4. Backpressure: redirect_ready held 0 for 4 cycles → redirect_valid and redirect_pc stay stable, pipe_stall=1 throughout; IDLE the cycle after ready=1.
5. exp_detect pulses during FLUSH → ignored, exp_dropped=1, original target is still delivered. Also: 5 increments with MAX_OUTSTANDING=4 → count stays at 4 and cnt_error=1.
6. rst asserted asynchronously mid-DRAIN → all outputs are 0 immediately; after release the block is in IDLE and never issues a redirect.
